// File: rtl/rv_isa_pkg.sv
// rv_isa_pkg: RV32I branch opcode, funct3 encodings and branch sequencer states
package rv_isa_pkg;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef enum logic [2:0] {IDLE, RD1, RD2, EXEC, RESP} branch_state_t;
endpackage

// File: rtl/branch_cmp.sv
// branch_cmp: combinational RV32I branch condition evaluation
module branch_cmp
  import rv_isa_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [2:0]      funct3,
  output logic            taken
);
  logic eq, lt, ltu;
  always_comb begin
    eq    = op1 == op2;
    lt    = $signed(op1) < $signed(op2);
    ltu   = op1 < op2;
    taken = funct3 == F3_BEQ  ? eq   :
            funct3 == F3_BNE  ? !eq  :
            funct3 == F3_BLT  ? lt   :
            funct3 == F3_BGE  ? !lt  :
            funct3 == F3_BLTU ? ltu  :
            funct3 == F3_BGEU ? !ltu : 1'b0;
  end
endmodule

// File: rtl/branch_exec_ctrl.sv
// branch_exec_ctrl: multi-cycle RV32I conditional branch sequencer (optional stats via BRANCH_EXEC_STATS_EN)
module branch_exec_ctrl
  import rv_isa_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             rf_ren,
  output logic [RF_AW-1:0] rf_raddr,
  input  logic [XLEN-1:0]  rf_rdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_taken,
  output logic [XLEN-1:0]  rsp_target,
  output logic             rsp_illegal,
  output logic             rsp_misalign
`ifdef BRANCH_EXEC_STATS_EN
  ,
  output logic [31:0]      stat_taken,
  output logic [31:0]      stat_not_taken
`endif
);
  branch_state_t state;
  logic [XLEN-1:0] pc, imm, op1, target;
  logic [2:0] f3;
  logic [4:0] rs2;
  logic in_illegal, taken;
  always_comb begin
    in_illegal = in_instr[6:0] != OPC_BRANCH || in_instr[14:13] == 2'b01;
    target     = pc + (taken ? imm : XLEN'(4));
  end
  // op2 is consumed straight off the RF port during EXEC
  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .op1    (op1),
    .op2    (rf_rdata),
    .funct3 (f3),
    .taken  (taken)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      rf_ren       <= 1'b0;
      rf_raddr     <= '0;
      rsp_valid    <= 1'b0;
      rsp_taken    <= 1'b0;
      rsp_target   <= '0;
      rsp_illegal  <= 1'b0;
      rsp_misalign <= 1'b0;
      pc           <= '0;
      imm          <= '0;
      op1          <= '0;
      f3           <= '0;
      rs2          <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          pc       <= in_pc;
          imm      <= {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
          f3       <= in_instr[14:12];
          rs2      <= in_instr[24:20];
          in_ready <= 1'b0;
          if (in_illegal) begin
            state        <= RESP;
            rsp_valid    <= 1'b1;
            rsp_illegal  <= 1'b1;
            rsp_taken    <= 1'b0;
            rsp_misalign <= 1'b0;
            rsp_target   <= in_pc + XLEN'(4);
          end else begin
            state    <= RD1;
            rf_ren   <= 1'b1;
            rf_raddr <= RF_AW'(in_instr[19:15]);
          end
        end
        RD1: begin
          state    <= RD2;
          rf_raddr <= RF_AW'(rs2);
        end
        RD2: begin
          state    <= EXEC;
          op1      <= rf_rdata;
          rf_ren   <= 1'b0;
          rf_raddr <= '0;
        end
        EXEC: begin
          state        <= RESP;
          rsp_valid    <= 1'b1;
          rsp_illegal  <= 1'b0;
          rsp_taken    <= taken;
          rsp_target   <= target;
          rsp_misalign <= taken & target[1];
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef BRANCH_EXEC_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_taken     <= '0;
      stat_not_taken <= '0;
    end else if (state == RESP && rsp_ready && !rsp_illegal) begin
      if (rsp_taken) stat_taken <= stat_taken + {31'b0, ~&stat_taken};
      else stat_not_taken <= stat_not_taken + {31'b0, ~&stat_not_taken};
    end
  end
`endif
endmodule

// File: tb/tb_branch_exec_ctrl.sv
// tb_branch_exec_ctrl: directed self-checking bench for branch_exec_ctrl with a 1-cycle RF model
module tb_branch_exec_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic        rf_ren;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_taken, rsp_illegal, rsp_misalign;
  logic [31:0] rsp_target;
  logic [31:0] regs [32];
  int checks = 0, failures = 0;
  int exp_tk = 0, exp_nt = 0;
`ifdef BRANCH_EXEC_STATS_EN
  logic [31:0] stat_taken, stat_not_taken;
`endif

  branch_exec_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .rf_ren       (rf_ren),
    .rf_raddr     (rf_raddr),
    .rf_rdata     (rf_rdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_taken    (rsp_taken),
    .rsp_target   (rsp_target),
    .rsp_illegal  (rsp_illegal),
    .rsp_misalign (rsp_misalign)
`ifdef BRANCH_EXEC_STATS_EN
    ,
    .stat_taken     (stat_taken),
    .stat_not_taken (stat_not_taken)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rf_ren) rf_rdata <= (rf_raddr == 5'd0) ? 32'd0 : regs[rf_raddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                     input int lat, input int hold, input logic tk,
                     input logic [31:0] tgt, input logic il, input logic mis);
    int cyc;
    logic saw_ren;
    logic [34:0] snap;
    @(negedge clk);
    chk({tag, ".in_ready0"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    saw_ren = 1'b0;
    while (!rsp_valid && cyc < 20) begin
      saw_ren |= rf_ren;
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc), 32'(lat));
    chk({tag, ".rf_ren_used"}, 32'(saw_ren), 32'(!il));
    chk({tag, ".taken"}, 32'(rsp_taken), 32'(tk));
    chk({tag, ".target"}, rsp_target, tgt);
    chk({tag, ".illegal"}, 32'(rsp_illegal), 32'(il));
    chk({tag, ".misalign"}, 32'(rsp_misalign), 32'(mis));
    snap = {rsp_valid, rsp_taken, rsp_illegal, rsp_misalign, rsp_target[30:0]};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_rsp"}, {rsp_valid, rsp_taken, rsp_illegal, rsp_misalign, rsp_target[31:4]},
          {snap[34], snap[33], snap[32], snap[31], tgt[31:4]});
      chk({tag, ".hold_ready"}, 32'({in_ready, rf_ren}), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".post_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".post_ready"}, 32'(in_ready), 32'd1);
    if (!il) begin
      if (tk) exp_tk++;
      else exp_nt++;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.rf_ren", 32'(rf_ren), 32'd0);
    chk("reset.rf_raddr", 32'(rf_raddr), 32'd0);
    chk("reset.rsp_flags", 32'({rsp_valid, rsp_taken, rsp_illegal, rsp_misalign}), 32'd0);
    chk("reset.rsp_target", rsp_target, 32'd0);
    regs[13] = 32'd5;
    regs[21] = 32'd3;
    run("bgeu_taken", 32'h0F56F6E3, 32'h100, 4, 0, 1'b1, 32'h9EC, 1'b0, 1'b0);
    regs[13] = 32'd3;
    regs[21] = 32'd5;
    run("bgeu_not", 32'h0F56F6E3, 32'h100, 4, 0, 1'b0, 32'h104, 1'b0, 1'b0);
    regs[1] = 32'hFFFFFFFF;
    regs[2] = 32'd1;
    run("blt", 32'h0020C463, 32'h400, 4, 0, 1'b1, 32'h408, 1'b0, 1'b0);
    run("bltu", 32'h0020E463, 32'h400, 4, 0, 1'b0, 32'h404, 1'b0, 1'b0);
    run("bne_neg_wrap", 32'hFE209EE3, 32'h0, 4, 0, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0);
    run("beq_misalign", 32'h00000163, 32'h500, 4, 0, 1'b1, 32'h502, 1'b0, 1'b1);
    regs[13] = 32'd5;
    regs[21] = 32'd3;
    run("backpressure", 32'h0F56F6E3, 32'h100, 4, 6, 1'b1, 32'h9EC, 1'b0, 1'b0);
    run("rtype", 32'h00208033, 32'h200, 1, 0, 1'b0, 32'h204, 1'b1, 1'b0);
    run("f3_010", 32'h0020A063, 32'h300, 1, 0, 1'b0, 32'h304, 1'b1, 1'b0);
`ifdef BRANCH_EXEC_STATS_EN
    chk("stat_taken", stat_taken, 32'(exp_tk));
    chk("stat_not_taken", stat_not_taken, 32'(exp_nt));
`endif
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = 32'h0F56F6E3;
    in_pc    = 32'h100;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_rd2.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rd2.rf_ren", 32'(rf_ren), 32'd0);
    chk("rst_rd2.in_ready", 32'(in_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("rst_rd2.no_rsp", 32'(rsp_valid), 32'd0);
    exp_tk = 0;
    exp_nt = 0;
    run("after_rst", 32'h0F56F6E3, 32'h100, 4, 0, 1'b1, 32'h9EC, 1'b0, 1'b0);
`ifdef BRANCH_EXEC_STATS_EN
    chk("stat_taken_rst", stat_taken, 32'(exp_tk));
    chk("stat_not_taken_rst", stat_not_taken, 32'(exp_nt));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
